// File: rtl/updown_mod_counter.sv
// updown_mod_counter: prescaled up/down modulo-MOD counter with parallel load,
// terminal count, one-cycle wrap pulse and sticky overflow flag.
// Optional build macro UDC_SATURATE_EN: steps past a bound hold q instead of
// wrapping; wrap never asserts and ovf flags the attempted overstep.
module updown_mod_counter #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MOD      = 16,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
   localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MOD);
   localparam logic [WIDTH:0]   ONE_W   = (WIDTH + 1)'(1);
   localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    ps_q, ps_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic             step;
   logic             bound;
   logic [WIDTH:0]   nxt_w;

   // Next-state: load beats a count step, which beats hold.
   // Bound detection uses the extra bit of nxt_w: carry reaching MOD going up,
   // borrow out of zero going down.
   always_comb begin
      cnt_d  = cnt_q;
      ps_d   = ps_q;
      wrap_d = 1'b0;
      ovf_d  = ovf_q & ~ovf_clr;
      step   = 1'b0;
      bound  = 1'b0;
      nxt_w  = '0;

      if (load) begin
         cnt_d = ({1'b0, load_val} < MOD_W) ? load_val : TOP;
         ps_d  = '0;
      end else if (en) begin
         if (ps_q == PS_LAST) begin
            ps_d = '0;
            step = 1'b1;
         end else begin
            ps_d = ps_q + 1'b1;
         end
      end

      if (step) begin
         if (up) begin
            nxt_w = {1'b0, cnt_q} + ONE_W;
            bound = (nxt_w >= MOD_W);
         end else begin
            nxt_w = {1'b0, cnt_q} - ONE_W;
            bound = nxt_w[WIDTH];
         end

         if (bound) begin
`ifdef UDC_SATURATE_EN
            cnt_d  = cnt_q;
            ovf_d  = 1'b1;
`else
            cnt_d  = up ? '0 : TOP;
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
`endif
         end else begin
            cnt_d = nxt_w[WIDTH-1:0];
         end
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_q  <= '0;
         ps_q   <= '0;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         ps_q   <= ps_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
      end
   end

   // Output decode; tc follows the live direction input.
   always_comb begin
      q    = cnt_q;
      qb   = ~cnt_q;
      wrap = wrap_q;
      ovf  = ovf_q;
      tc   = (up && (cnt_q == TOP)) || (!up && (cnt_q == '0));
   end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter (WIDTH=4, MOD=10) with PRESCALE=1
// and PRESCALE=3 instances; expectations follow UDC_SATURATE_EN when defined.
module tb_updown_mod_counter;

   localparam int unsigned M = 10;
`ifdef UDC_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clr, en, up, load, ovf_clr;
   logic [3:0] load_val;
   logic [3:0] q, qb, q3, qb3;
   logic       tc, wrap, ovf, tc3, wrap3, ovf3;

   typedef struct {
      bit         sel;
      logic [3:0] q;
      bit         wrap;
      bit         ovf;
      bit         tc;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   updown_mod_counter #(.WIDTH(4), .MOD(10), .PRESCALE(1)) dut (
      .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
      .ovf_clr(ovf_clr), .q(q), .qb(qb), .tc(tc), .wrap(wrap), .ovf(ovf));

   updown_mod_counter #(.WIDTH(4), .MOD(10), .PRESCALE(3)) dut3 (
      .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
      .ovf_clr(ovf_clr), .q(q3), .qb(qb3), .tc(tc3), .wrap(wrap3), .ovf(ovf3));

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply inputs on the falling edge, then queue the expected post-edge state.
   task automatic cyc(input bit e, input bit u, input bit l, input logic [3:0] lv,
                      input bit oc, input bit sel, input logic [3:0] eq,
                      input bit ew, input bit eo, input bit et, input string nm);
      exp_t x;
      @(negedge clk);
      en = e; up = u; load = l; load_val = lv; ovf_clr = oc;
      @(posedge clk);
      #1;
      x.sel = sel; x.q = eq; x.wrap = ew; x.ovf = eo; x.tc = et; x.name = nm;
      sb.push_back(x);
   endtask

   // Monitor: invariants every cycle, then drain queued expectations.
   initial begin
      exp_t       e;
      logic [3:0] nq;
      forever begin
         @(posedge clk);
         #2;
         nq = ~q;
         chk("qb_inv", qb, nq);
         chk("q_range", (q < M), 1);
         nq = ~q3;
         chk("qb3_inv", qb3, nq);
         chk("q3_range", (q3 < M), 1);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.sel) begin
               chk({e.name, ".q"}, q, e.q);
               chk({e.name, ".wrap"}, wrap, e.wrap);
               chk({e.name, ".ovf"}, ovf, e.ovf);
               chk({e.name, ".tc"}, tc, e.tc);
            end else begin
               chk({e.name, ".q3"}, q3, e.q);
               chk({e.name, ".wrap3"}, wrap3, e.wrap);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] eq;
      logic [3:0] dn_def [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
      logic [3:0] dn_sat [5] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
      logic [3:0] up_def [4] = '{4'd9, 4'd0, 4'd1, 4'd2};
      bit         p3_en  [7] = '{1, 1, 0, 1, 1, 1, 1};
      logic [3:0] p3_q   [7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};

      clr = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; ovf_clr = 1'b0;
      #2 clr = 1'b0;

      // Reset state, tc in both directions.
      cyc(0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, "rst_up");
      cyc(0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, "rst_dn");
      @(negedge clk);
      #1 clr = 1'b1;

      // Count up 12 steps through the top bound.
      for (int i = 1; i <= 12; i++) begin
         eq = SAT ? ((i > 9) ? 4'd9 : 4'(i)) : 4'(i % 10);
         cyc(1, 1, 0, 4'd0, 0, 0, eq, (!SAT && i == 10), (i >= 10), (eq == 4'd9), "up_count");
      end

      // Load 3 then count down through zero.
      cyc(1, 0, 1, 4'd3, 0, 0, 4'd3, 0, 1, 0, "load3");
      for (int k = 0; k < 5; k++) begin
         eq = SAT ? dn_sat[k] : dn_def[k];
         cyc(1, 0, 0, 4'd0, 0, 0, eq, (!SAT && k == 3), 1, (eq == 4'd0), "down");
      end

      // Load clamping, ovf set-wins, ovf clear, hold with direction change.
      cyc(1, 1, 1, 4'd14, 0, 0, 4'd9, 0, 1, 1, "load14_clamp");
      cyc(0, 0, 1, 4'd10, 0, 0, 4'd9, 0, 1, 0, "load10_clamp");
      cyc(1, 1, 0, 4'd0, 1, 0, SAT ? 4'd9 : 4'd0, !SAT, 1, SAT, "ovf_set_wins");
      cyc(0, 1, 0, 4'd0, 1, 0, SAT ? 4'd9 : 4'd0, 0, 0, SAT, "ovf_clr");
      cyc(0, 0, 0, 4'd0, 0, 0, SAT ? 4'd9 : 4'd0, 0, 0, !SAT, "hold_dn");

      // Load 8, up 4 steps across the top bound.
      cyc(1, 1, 1, 4'd8, 0, 0, 4'd8, 0, 0, 0, "load8");
      for (int k = 0; k < 4; k++) begin
         eq = SAT ? 4'd9 : up_def[k];
         cyc(1, 1, 0, 4'd0, 0, 0, eq, (!SAT && k == 1), (k >= 1), (eq == 4'd9), "up_from8");
      end

      // PRESCALE=3 instance: gated enable, phase kept across direction change.
      cyc(1, 1, 1, 4'd0, 0, 1, 4'd0, 0, 0, 0, "p3_load");
      for (int k = 0; k < 7; k++)
         cyc(p3_en[k], 1, 0, 4'd0, 0, 1, p3_q[k], 0, 0, 0, "p3_en");
      cyc(1, 1, 0, 4'd0, 0, 1, 4'd2, 0, 0, 0, "p3_dir_a");
      cyc(1, 0, 0, 4'd0, 0, 1, 4'd2, 0, 0, 0, "p3_dir_b");
      cyc(1, 0, 0, 4'd0, 0, 1, 4'd1, 0, 0, 0, "p3_dir_c");
      cyc(1, 0, 0, 4'd0, 0, 1, 4'd1, 0, 0, 0, "p3_pre_rst");

      // Asynchronous clear between edges aborts the pending step.
      #2 clr = 1'b0;
      #1;
      chk("async_q3", q3, 4'd0);
      chk("async_qb3", qb3, 4'hF);
      chk("async_q", q, 4'd0);
      chk("async_ovf", ovf, 0);
      chk("async_wrap", wrap, 0);
      #1 clr = 1'b1;
      cyc(1, 1, 0, 4'd0, 0, 1, 4'd0, 0, 0, 0, "p3_rel1");
      cyc(1, 1, 0, 4'd0, 0, 1, 4'd0, 0, 0, 0, "p3_rel2");
      cyc(1, 1, 0, 4'd0, 0, 1, 4'd1, 0, 0, 0, "p3_rel3");

      @(posedge clk);
      #5;
      chk("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter MOD, default 16: count modulus, range 0..MOD-1; legal 2 <= MOD <= 2**WIDTH.
REQ-003 Parameter PRESCALE, default 1: enabled cycles per count step; legal 1..256.
REQ-004 clk  input  1: single clock; all state changes on rising edge.
REQ-005 clr  input  1: asynchronous, active-low reset.
REQ-006 en  input  1: count enable; prescaler advances only while high.
REQ-007 up  input  1: direction; 1 = increment, 0 = decrement.
REQ-008 load  input  1: synchronous parallel load strobe.
REQ-009 load_val  input  WIDTH: value applied on load.
REQ-010 ovf_clr  input  1: clears sticky ovf.
REQ-011 q  output  WIDTH: registered count.
REQ-012 qb  output  WIDTH: bitwise complement of q.
REQ-013 tc  output  1: combinational terminal count, (up && q==MOD-1) || (!up && q==0).
REQ-014 wrap  output  1: registered one-cycle pulse after a wrap step.
REQ-015 ovf  output  1: sticky overflow/underflow flag.

Function
REQ-016 Fully synchronous design: every flop clocked by clk; no derived or rippled clocks.
REQ-017 Priority per edge: load > count step > hold.
REQ-018 Load: q <= load_val if load_val < MOD, else q <= MOD-1; prescaler counter <= 0; no wrap, ovf unchanged.
REQ-019 Prescaler: internal counter 0..PRESCALE-1 increments on each edge with en=1 and load=0; step occurs on the edge where it equals PRESCALE-1, then it returns to 0.
REQ-020 With PRESCALE=1 a step occurs on every edge with en=1 and load=0.
REQ-021 en=0: q and prescaler hold; up may change freely without effect.
REQ-022 Up step: q <= q+1; at q==MOD-1, q <= 0 (wrap).
REQ-023 Down step: q <= q-1; at q==0, q <= MOD-1 (wrap).
REQ-024 Arithmetic done in WIDTH+1 bits; q never holds a value >= MOD.
REQ-025 wrap high exactly for the cycle following a wrap edge; low otherwise, including after load.
REQ-026 ovf set on any wrap edge; cleared by ovf_clr=1 on an edge; set and ovf_clr on the same edge -> ovf=1 (set wins).
REQ-027 Direction change takes effect on the next step; prescaler phase is preserved across direction changes.
REQ-028 qb == ~q at all times, including during reset.

Reset
REQ-029 clr=0 asynchronously forces q=0, qb=all ones, wrap=0, ovf=0, prescaler=0, independent of clk.
REQ-030 Reset asserted mid-count aborts the pending step; first step after release needs a full PRESCALE enabled cycles.
REQ-031 Deassertion is a registered release; the first edge with clr=1 evaluates normally.

Configuration
REQ-032 Macro UDC_SATURATE_EN, when defined: a step past a bound holds q (MOD-1 up, 0 down), wrap stays 0, ovf sets on the attempted overstep.
REQ-033 Macro UDC_SATURATE_EN not defined: wrap-around per REQ-022/023/025; the saturate logic is not present.

Verification (WIDTH=4, MOD=10, PRESCALE=1 unless noted)
REQ-034 Reset, en=1 up=1 for 12 cycles -> q 1..9,0,1,2; wrap high one cycle after the 9->0 step; ovf=1.
REQ-035 load_val=3, then down for 5 cycles -> q 3,2,1,0,9,8; tc=1 while q=0; wrap pulse after the 0->9 step.
REQ-036 load_val=14 -> q=9, tc=1 (up); ovf_clr and wrap on the same edge -> ovf stays 1; ovf_clr alone -> ovf 0.
REQ-037 PRESCALE=3, en toggling 1,1,0,1,1,1 -> q steps once after the 3rd enabled cycle and again 3 enabled cycles later; clr pulsed low between clock edges -> q=0 immediately.
REQ-038 UDC_SATURATE_EN defined, up from q=8 for 4 cycles -> q 9,9,9,9; wrap never asserts; ovf=1.
REQ-039 Every scenario: assert qb == ~q and q < MOD on every cycle.
